// File: rtl/seg_scan.sv
// seg_scan: multiplexed 7-segment scanner for the alarm-clock display.
// Walks the six digits (S0, S1, M0, M1, H0, H1) onto one shared segment bus,
// blanks the first BLANK clocks of each slot to suppress ghosting, and can
// blink any digit pair by hiding its segments every other blink half-period.
module seg_scan #(
    parameter int DWELL     = 1000,
    parameter int BLANK     = 8,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] S0disp,
    input  logic [6:0] S1disp,
    input  logic [6:0] M0disp,
    input  logic [6:0] M1disp,
    input  logic [6:0] H0disp,
    input  logic [6:0] H1disp,
    input  logic [2:0] blink_en,
    output logic [6:0] seg_out,
    output logic [5:0] dig_sel,
    output logic       frame_start
);

    localparam int DW = $clog2(DWELL);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [DW-1:0] dwell_ct;
    logic [2:0]    idx;
    logic [FW-1:0] frame_ct;
    logic          phase;

    logic          blank_slot;
    logic          pair_blink;
    logic [6:0]    seg_pick;
    logic [6:0]    seg_nx;
    logic [5:0]    dig_nx;
    logic          frame_start_nx;

    // Hides a digit's segments while its pair is in the blink-off half-period.
    function automatic logic [6:0] blink_mask(input logic [6:0] seg, input logic hide);
        return hide ? 7'd0 : seg;
    endfunction

    // Anti-ghosting blank window; with BLANK=0 no slot is ever blanked.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign blank_slot = 1'b0;
        end else begin : g_blank
            localparam logic [DW-1:0] BLANK_V = DW'(BLANK);
            assign blank_slot = (dwell_ct < BLANK_V);
        end
    endgenerate

    // Slot, digit and blink-frame counters; idx advances on each dwell wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dwell_ct <= '0;
            idx      <= '0;
            frame_ct <= '0;
            phase    <= 1'b0;
        end else if (dwell_ct == DWELL_LAST) begin
            dwell_ct <= '0;
            if (idx == 3'd5) begin
                idx <= '0;
                if (frame_ct == FRAME_LAST) begin
                    frame_ct <= '0;
                    phase    <= ~phase;
                end else begin
                    frame_ct <= frame_ct + 1'b1;
                end
            end else begin
                idx <= idx + 3'd1;
            end
        end else begin
            dwell_ct <= dwell_ct + 1'b1;
        end
    end

    // Next-output decode: select the digit, apply blink and blank windows.
    always_comb begin
        seg_pick   = 7'd0;
        pair_blink = 1'b0;
        case (idx)
            3'd0:    seg_pick = S0disp;
            3'd1:    seg_pick = S1disp;
            3'd2:    seg_pick = M0disp;
            3'd3:    seg_pick = M1disp;
            3'd4:    seg_pick = H0disp;
            3'd5:    seg_pick = H1disp;
            default: seg_pick = 7'd0;
        endcase
        case (idx[2:1])
            2'd0:    pair_blink = blink_en[0];
            2'd1:    pair_blink = blink_en[1];
            2'd2:    pair_blink = blink_en[2];
            default: pair_blink = 1'b0;
        endcase

        frame_start_nx = (idx == 3'd0) && (dwell_ct == '0);
        if (blank_slot) begin
            dig_nx = 6'd0;
            seg_nx = 7'd0;
        end else begin
            // Digit enable stays on during blink-off; only segments go dark.
            dig_nx = 6'd1 << idx;
            seg_nx = blink_mask(seg_pick, phase && pair_blink);
        end
    end

    // Registered outputs, one clock behind the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_out     <= 7'd0;
            dig_sel     <= 6'd0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= seg_nx;
            dig_sel     <= dig_nx;
            frame_start <= frame_start_nx;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan: DWELL=4, BLANK=1, BLINK_DIV=2, plus a BLANK=0 copy.
module tb_seg_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] s0, s1, m0, m1, h0, h1;
    logic [2:0] blink_en;
    logic [6:0] seg_out, nb_seg;
    logic [5:0] dig_sel, nb_dig;
    logic       frame_start, nb_fs;

    int tests_run    = 0;
    int tests_failed = 0;
    int ecount       = 0;

    always #5 clk = ~clk;

    seg_scan #(.DWELL(4), .BLANK(1), .BLINK_DIV(2)) u_dut (
        .clk(clk), .rst(rst),
        .S0disp(s0), .S1disp(s1), .M0disp(m0), .M1disp(m1), .H0disp(h0), .H1disp(h1),
        .blink_en(blink_en),
        .seg_out(seg_out), .dig_sel(dig_sel), .frame_start(frame_start)
    );

    seg_scan #(.DWELL(4), .BLANK(0), .BLINK_DIV(2)) u_nb (
        .clk(clk), .rst(rst),
        .S0disp(s0), .S1disp(s1), .M0disp(m0), .M1disp(m1), .H0disp(h0), .H1disp(h1),
        .blink_en(blink_en),
        .seg_out(nb_seg), .dig_sel(nb_dig), .frame_start(nb_fs)
    );

    task automatic step();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ecount = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        tests_run++;
        if ({seg_out, dig_sel, frame_start} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got seg=%h dig=%b fs=%b, expected all 0", seg_out, dig_sel, frame_start);
        end
        step();
        step();
        tests_run++;
        if ({seg_out, dig_sel, frame_start} !== 14'd0) begin
            tests_failed++;
            $display("FAIL reset_held: got seg=%h dig=%b fs=%b, expected all 0", seg_out, dig_sel, frame_start);
        end
    endtask

    task automatic test_scan_order();
        logic [5:0] exp_dig;
        logic [6:0] exp_seg;
        logic       exp_fs;
        int         slot;
        blink_en = 3'b000;
        apply_reset();
        for (int e = 1; e <= 25; e++) begin
            step();
            slot = ((e - 1) / 4) % 6;
            if ((e - 1) % 4 == 0) begin
                exp_dig = 6'd0;
                exp_seg = 7'd0;
            end else begin
                exp_dig = 6'(1 << slot);
                exp_seg = 7'(1 << slot);
            end
            exp_fs = (e == 1) || (e == 25);
            tests_run++;
            if (dig_sel !== exp_dig || seg_out !== exp_seg || frame_start !== exp_fs) begin
                tests_failed++;
                $display("FAIL scan_order edge %0d: got dig=%b seg=%h fs=%b, expected dig=%b seg=%h fs=%b",
                         e, dig_sel, seg_out, frame_start, exp_dig, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_blink();
        logic [5:0] exp_dig;
        logic [6:0] exp_seg;
        int         slot;
        int         frame;
        blink_en = 3'b010;
        apply_reset();
        for (int e = 1; e <= 120; e++) begin
            step();
            slot  = ((e - 1) / 4) % 6;
            frame = (e - 1) / 24;
            if ((e - 1) % 4 == 0) begin
                exp_dig = 6'd0;
                exp_seg = 7'd0;
            end else begin
                exp_dig = 6'(1 << slot);
                if ((frame == 2 || frame == 3) && (slot == 2 || slot == 3))
                    exp_seg = 7'd0;
                else
                    exp_seg = 7'(1 << slot);
            end
            tests_run++;
            if (dig_sel !== exp_dig || seg_out !== exp_seg) begin
                tests_failed++;
                $display("FAIL blink edge %0d: got dig=%b seg=%h, expected dig=%b seg=%h",
                         e, dig_sel, seg_out, exp_dig, exp_seg);
            end
        end
        blink_en = 3'b000;
    endtask

    task automatic test_async_reset();
        blink_en = 3'b000;
        apply_reset();
        for (int e = 1; e <= 10; e++) step();
        tests_run++;
        if (dig_sel !== 6'b000100 || seg_out !== 7'h04) begin
            tests_failed++;
            $display("FAIL async_pre edge 10: got dig=%b seg=%h, expected dig=000100 seg=04", dig_sel, seg_out);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({seg_out, dig_sel, frame_start} !== 14'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got seg=%h dig=%b fs=%b, expected all 0 before next edge", seg_out, dig_sel, frame_start);
        end
        @(negedge clk);
        rst = 1'b1;
        ecount = 0;
        step();
        tests_run++;
        if (frame_start !== 1'b1 || dig_sel !== 6'd0 || seg_out !== 7'd0) begin
            tests_failed++;
            $display("FAIL async_edge1: got fs=%b dig=%b seg=%h, expected fs=1 dig=000000 seg=00", frame_start, dig_sel, seg_out);
        end
        for (int e = 2; e <= 4; e++) begin
            step();
            tests_run++;
            if (dig_sel !== 6'b000001 || seg_out !== 7'h01 || frame_start !== 1'b0) begin
                tests_failed++;
                $display("FAIL async_s0 edge %0d: got dig=%b seg=%h fs=%b, expected dig=000001 seg=01 fs=0",
                         e, dig_sel, seg_out, frame_start);
            end
        end
    endtask

    task automatic test_live_update();
        blink_en = 3'b000;
        s0 = 7'h01;
        apply_reset();
        step();
        step();
        tests_run++;
        if (seg_out !== 7'h01) begin
            tests_failed++;
            $display("FAIL live_edge2: got seg=%h, expected 01", seg_out);
        end
        s0 = 7'h7F;
        for (int e = 3; e <= 4; e++) begin
            step();
            tests_run++;
            if (seg_out !== 7'h7F || dig_sel !== 6'b000001) begin
                tests_failed++;
                $display("FAIL live_edge%0d: got seg=%h dig=%b, expected seg=7f dig=000001", e, seg_out, dig_sel);
            end
        end
        s0 = 7'h01;
    endtask

    task automatic test_no_blank();
        int slot;
        blink_en = 3'b000;
        apply_reset();
        for (int e = 1; e <= 26; e++) begin
            step();
            slot = ((e - 1) / 4) % 6;
            tests_run++;
            if (nb_dig !== 6'(1 << slot) || nb_seg !== 7'(1 << slot)) begin
                tests_failed++;
                $display("FAIL no_blank edge %0d: got dig=%b seg=%h, expected dig=%b seg=%h",
                         e, nb_dig, nb_seg, 6'(1 << slot), 7'(1 << slot));
            end
        end
    endtask

    task automatic test_blink_release();
        blink_en = 3'b010;
        apply_reset();
        for (int e = 1; e <= 58; e++) step();
        tests_run++;
        if (dig_sel !== 6'b000100 || seg_out !== 7'h00) begin
            tests_failed++;
            $display("FAIL release_hidden edge 58: got dig=%b seg=%h, expected dig=000100 seg=00", dig_sel, seg_out);
        end
        blink_en = 3'b000;
        for (int e = 59; e <= 60; e++) begin
            step();
            tests_run++;
            if (dig_sel !== 6'b000100 || seg_out !== 7'h04) begin
                tests_failed++;
                $display("FAIL release_shown edge %0d: got dig=%b seg=%h, expected dig=000100 seg=04", e, dig_sel, seg_out);
            end
        end
    endtask

    initial begin
        s0 = 7'h01; s1 = 7'h02; m0 = 7'h04; m1 = 7'h08; h0 = 7'h10; h1 = 7'h20;
        blink_en = 3'b000;
        test_reset();
        test_scan_order();
        test_blink();
        test_async_reset();
        test_live_update();
        test_no_blank();
        test_blink_release();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
